fetch32: RTL and testbench

Instruction-fetch stage of the single-cycle 32-bit MIPS datapath, directly upstream of `control32`. It holds the program counter, a small word-addressed instruction memory programmed over a load port, and the next-PC logic (PC+4, BEQ/BNE branch, J jump). Each cycle it presents the current instruction to `control32` and the register file. It takes back `Branch_out`, `Jump_out` and the ALU zero flag to form the next PC.

---
 rtl/fetch32.sv | 162 ++++++++++++++++
 tb/tb_fetch32.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch32.sv
// fetch32: instruction-fetch stage of the single-cycle 32-bit MIPS datapath.
// Holds the PC, a word-addressed instruction memory filled over a load port,
// and the next-PC logic (PC+4, BEQ/BNE, J). Execution runs from RESET_PC
// until a 32'hFFFF_FFFF sentinel is fetched or the next PC leaves the memory.
//
// Control handshake: there is no valid/ready pair on this block. load_en and
// run are single-cycle requests that are accepted on the rising edge only
// when the FSM is in IDLE or HALT; in RUN they are ignored, and the requester
// sees the result through running_out / halted_out on the following cycle.
module fetch32 #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          run,
    input  logic                          Branch_in,
    input  logic                          Jump_in,
    input  logic                          Zero_in,
    output logic [31:0]                   instruction_out,
    output logic [31:0]                   pc_out,
    output logic [31:0]                   pc_plus4_out,
    output logic                          running_out,
    output logic                          halted_out,
    output logic                          fault_out,
    output logic [31:0]                   instr_count_out
);

    localparam int AW = $clog2(IMEM_DEPTH);

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        fault_q, fault_d;

    // Instruction storage; deliberately not reset so a program survives reset.
    logic [31:0] imem_q [IMEM_DEPTH];

    logic          mem_we;
    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetched;
    logic          is_sentinel;
    logic [31:0]   pc_plus4;
    logic [31:0]   branch_off;
    logic [31:0]   branch_target;
    logic [31:0]   jump_target;
    logic          branch_taken;
    logic [31:0]   next_pc;
    logic          next_out_of_range;

    // Combinational fetch and next-PC datapath for the instruction at pc_q.
    always_comb begin
        fetch_idx     = pc_q[AW+1:2];
        fetched       = imem_q[fetch_idx];
        is_sentinel   = (fetched == HALT_WORD);
        pc_plus4      = pc_q + 32'd4;
        branch_off    = {{14{fetched[15]}}, fetched[15:0], 2'b00};
        branch_target = pc_plus4 + branch_off;
        jump_target   = {pc_plus4[31:28], fetched[25:0], 2'b00};
        // instr[26] distinguishes BNE (1) from BEQ (0).
        branch_taken  = Branch_in && (Zero_in ^ fetched[26]);

        // Jump has priority over branch.
        if (Jump_in) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc_plus4;
        end

        // Any set bit above the word-index field means index >= IMEM_DEPTH.
        next_out_of_range = ((next_pc >> (AW + 2)) != 32'd0);
    end

    // Next-state, PC, fault and retired-instruction count.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        fault_d = fault_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                mem_we = load_en;
                if (run) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                    count_d = 32'd0;
                    fault_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (is_sentinel) begin
                    // Sentinel is not retired: PC and count both hold.
                    state_d = ST_HALT;
                end else begin
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 32'd1;
                    end
                    if (next_out_of_range) begin
                        // Faulting instruction is retired but PC stays on it.
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    // Memory write port, only enabled outside RUN.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            imem_q[load_addr] <= load_data;
        end
    end

    // Output decode; the sentinel and non-RUN states present a NOP.
    always_comb begin
        instruction_out = ((state_q == ST_RUN) && !is_sentinel) ? fetched : 32'h0;
        pc_out          = pc_q;
        pc_plus4_out    = pc_plus4;
        running_out     = (state_q == ST_RUN);
        halted_out      = (state_q == ST_HALT);
        fault_out       = fault_q;
        instr_count_out = count_q;
    end

endmodule

// File: tb/tb_fetch32.sv
// Bench for fetch32: a driver issues directed programs cycle by cycle and
// pushes the expected {pc, instruction} of each RUN cycle into exp_q; a
// monitor on the falling edge pops and compares whenever running_out is high.
module tb_fetch32;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        run;
    logic        Branch_in;
    logic        Jump_in;
    logic        Zero_in;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        running_out;
    logic        halted_out;
    logic        fault_out;
    logic [31:0] instr_count_out;

    logic [63:0] exp_q[$];
    int          n_cmp;
    int          n_fail;

    localparam logic [31:0] ADD1 = 32'h0000_0020;
    localparam logic [31:0] ADD2 = 32'h0109_5020;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    fetch32 #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .run             (run),
        .Branch_in       (Branch_in),
        .Jump_in         (Jump_in),
        .Zero_in         (Zero_in),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .pc_plus4_out    (pc_plus4_out),
        .running_out     (running_out),
        .halted_out      (halted_out),
        .fault_out       (fault_out),
        .instr_count_out (instr_count_out)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expected entry per RUN cycle.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && running_out) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL run_cycle: unexpected RUN cycle pc=%h instr=%h", pc_out, instruction_out);
            end else begin
                e = exp_q.pop_front();
                if ({pc_out, instruction_out} !== e) begin
                    n_fail++;
                    $display("FAIL run_cycle: got pc=%h instr=%h expected pc=%h instr=%h",
                             pc_out, instruction_out, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic do_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // One RUN cycle: expected pc/instruction plus control inputs for that cycle.
    task automatic step(input logic [31:0] epc, input logic [31:0] ein,
                        input logic br, input logic jp, input logic z);
        exp_q.push_back({epc, ein});
        Branch_in = br;
        Jump_in   = jp;
        Zero_in   = z;
        tick();
        Branch_in = 1'b0;
        Jump_in   = 1'b0;
        Zero_in   = 1'b0;
    endtask

    task automatic chk_halt(input string name, input logic [31:0] epc,
                            input logic [31:0] ecnt, input logic efault);
        chk({name, "_halted"}, {31'd0, halted_out}, 32'd1);
        chk({name, "_pc"}, pc_out, epc);
        chk({name, "_count"}, instr_count_out, ecnt);
        chk({name, "_fault"}, {31'd0, fault_out}, {31'd0, efault});
        chk({name, "_instr"}, instruction_out, 32'h0);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        run       = 1'b0;
        Branch_in = 1'b0;
        Jump_in   = 1'b0;
        Zero_in   = 1'b0;
        #2;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pc4", pc_plus4_out, 32'h4);
        chk("rst_instr", instruction_out, 32'h0);
        chk("rst_flags", {29'd0, running_out, halted_out, fault_out}, 32'h0);
        chk("rst_count", instr_count_out, 32'h0);
        #10;
        reset = 1'b0;

        // Straight-line program ending on the sentinel.
        load(6'd0, ADD1);
        load(6'd1, ADD2);
        load(6'd2, HALTW);
        do_run();
        step(32'd0, ADD1, 1'b0, 1'b0, 1'b0);
        step(32'd4, ADD2, 1'b0, 1'b0, 1'b0);
        step(32'd8, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_halt("seq", 32'd8, 32'd2, 1'b0);
        chk("seq_pc4", pc_plus4_out, 32'd12);
        chk("seq_running", {31'd0, running_out}, 32'd0);

        // BEQ taken: 0 -> 16.
        load(6'd0, 32'h1000_0003);
        load(6'd4, HALTW);
        do_run();
        step(32'd0, 32'h1000_0003, 1'b1, 1'b0, 1'b1);
        step(32'd16, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_halt("beq_t", 32'd16, 32'd1, 1'b0);

        // BEQ not taken: 0 -> 4.
        load(6'd1, HALTW);
        do_run();
        step(32'd0, 32'h1000_0003, 1'b1, 1'b0, 1'b0);
        step(32'd4, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_halt("beq_nt", 32'd4, 32'd1, 1'b0);

        // BNE taken with Zero=0: 0 -> 16.
        load(6'd0, 32'h1400_0003);
        do_run();
        step(32'd0, 32'h1400_0003, 1'b1, 1'b0, 1'b0);
        step(32'd16, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_halt("bne_t", 32'd16, 32'd1, 1'b0);

        // Jump to word 4, branch-to-self three times, then fall through.
        load(6'd0, 32'h0800_0004);
        load(6'd4, 32'h1000_FFFF);
        load(6'd5, HALTW);
        do_run();
        step(32'd0, 32'h0800_0004, 1'b0, 1'b1, 1'b0);
        step(32'd16, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
        step(32'd16, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
        step(32'd16, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
        step(32'd16, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0);
        step(32'd20, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_halt("self_br", 32'd20, 32'd5, 1'b0);

        // Jump wins over a taken branch: 0 -> 20 rather than 24.
        load(6'd0, 32'h0800_0005);
        load(6'd6, HALTW);
        do_run();
        step(32'd0, 32'h0800_0005, 1'b1, 1'b1, 1'b1);
        step(32'd20, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_halt("jprio", 32'd20, 32'd1, 1'b0);

        // Jump to word 64 faults; PC holds at the jump, it is counted.
        load(6'd0, 32'h0800_0040);
        do_run();
        step(32'd0, 32'h0800_0040, 1'b0, 1'b1, 1'b0);
        chk_halt("fault", 32'd0, 32'd1, 1'b1);

        // Load and run on the same edge: restart sees the new word, fault clears.
        load_en   = 1'b1;
        load_addr = 6'd0;
        load_data = ADD1;
        run       = 1'b1;
        tick();
        load_en   = 1'b0;
        run       = 1'b0;
        chk("rerun_fault", {31'd0, fault_out}, 32'd0);
        chk("rerun_count", instr_count_out, 32'd0);
        step(32'd0, ADD1, 1'b0, 1'b0, 1'b0);
        step(32'd4, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_halt("rerun", 32'd4, 32'd1, 1'b0);

        // Load during RUN is ignored; async reset mid-run at PC 12.
        load(6'd1, ADD1);
        load(6'd2, ADD1);
        load(6'd3, ADD1);
        load(6'd4, HALTW);
        do_run();
        step(32'd0, ADD1, 1'b0, 1'b0, 1'b0);
        load_en   = 1'b1;
        load_addr = 6'd3;
        load_data = 32'hDEAD_BEEF;
        step(32'd4, ADD1, 1'b0, 1'b0, 1'b0);
        load_en   = 1'b0;
        step(32'd8, ADD1, 1'b0, 1'b0, 1'b0);
        chk("mid_pc", pc_out, 32'd12);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_pc4", pc_plus4_out, 32'h4);
        chk("arst_instr", instruction_out, 32'h0);
        chk("arst_flags", {29'd0, running_out, halted_out, fault_out}, 32'h0);
        chk("arst_count", instr_count_out, 32'h0);
        #2;
        reset = 1'b0;
        tick();
        do_run();
        step(32'd0, ADD1, 1'b0, 1'b0, 1'b0);
        step(32'd4, ADD1, 1'b0, 1'b0, 1'b0);
        step(32'd8, ADD1, 1'b0, 1'b0, 1'b0);
        step(32'd12, ADD1, 1'b0, 1'b0, 1'b0);
        step(32'd16, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_halt("noload", 32'd16, 32'd4, 1'b0);

        tick();
        chk("exp_q_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
